// File: rtl/game_pkg.sv
// Shared game types and playfield constants for fighter, projectile and renderer blocks.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package game_pkg;

  // Lifecycle of one projectile slot
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLYING  = 2'd1,
    EXPLODE = 2'd2
  } slot_state_t;

  // Playfield size in pixels
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Default bounding boxes, shared with the player and renderer
  localparam int DEF_PROJ_W = 16;
  localparam int DEF_PROJ_H = 16;
  localparam int DEF_OPP_W  = 32;
  localparam int DEF_OPP_H  = 48;

endpackage

// File: rtl/projectile_slot.sv
// One projectile: holds state/position/direction/explode counter, moves on tick, tests overlap.
// Latency: state and position update one cycle after the spawn or tick cycle; hit is combinational.
// Backpressure: none; spawn is only issued by the parent while this slot is IDLE.
module projectile_slot
  import game_pkg::*;
#(
  parameter int X_W           = 10,
  parameter int SPEED         = 4,
  parameter int SCREEN_W      = game_pkg::SCREEN_W,
  parameter int PROJ_W        = DEF_PROJ_W,
  parameter int PROJ_H        = DEF_PROJ_H,
  parameter int OPP_W         = DEF_OPP_W,
  parameter int OPP_H         = DEF_OPP_H,
  parameter int EXPLODE_TICKS = 8
)(
  input  logic           clk,
  input  logic           start,
  input  logic           tick,
  input  logic           spawn,
  input  logic           direction,
  input  logic [X_W-1:0] spawn_x,
  input  logic [X_W-1:0] spawn_y,
  input  logic [X_W-1:0] opponent_x,
  input  logic [X_W-1:0] opponent_y,
  output slot_state_t    state,
  output logic [X_W-1:0] x,
  output logic [X_W-1:0] y,
  output logic           hit
);

  localparam int XW1   = X_W + 1;
  localparam int CNT_W = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;

  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic [X_W:0]     nx;
  logic             overlap;
  logic             off_screen;

  // Candidate next position and its overlap / off-screen tests, all at X_W+1 bits
  always_comb begin
    nx = dir ? ({1'b0, x} + XW1'(SPEED)) : ({1'b0, x} - XW1'(SPEED));
    overlap = (nx < ({1'b0, opponent_x} + XW1'(OPP_W))) &&
              ((nx + XW1'(PROJ_W)) > {1'b0, opponent_x}) &&
              ({1'b0, y} < ({1'b0, opponent_y} + XW1'(OPP_H))) &&
              (({1'b0, y} + XW1'(PROJ_H)) > {1'b0, opponent_y});
    // Left exit is judged on the current x so the subtraction never has to be trusted after wrap
    off_screen = dir ? (nx > XW1'(SCREEN_W - PROJ_W)) : (x < X_W'(SPEED));
    hit = tick && (state == FLYING) && overlap;
  end

  // Slot FSM: spawn from IDLE, move/hit/exit while FLYING, count down in EXPLODE
  always_ff @(posedge clk) begin
    if (start) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      dir   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (spawn) begin
            state <= FLYING;
            x     <= spawn_x;
            y     <= spawn_y;
            dir   <= direction;
          end
        end
        FLYING: begin
          if (tick) begin
            if (overlap) begin
              // Hit wins over leaving the screen
              state <= EXPLODE;
              x     <= nx[X_W-1:0];
              cnt   <= CNT_W'(EXPLODE_TICKS - 1);
            end else if (off_screen) begin
              state <= IDLE;
            end else begin
              x <= nx[X_W-1:0];
            end
          end
        end
        EXPLODE: begin
          if (tick) begin
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS projectiles for one fighter: lowest-free-slot spawn, hit OR and hit counter.
// Latency: all outputs registered, one cycle after the fire or tick cycle.
// Backpressure: fire is never stalled; a refused request (pool full or cooldown via
//   PROJECTILE_POOL_COOLDOWN_EN) pulses fire_drop instead of fire_ack.
module projectile_pool
  import game_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int X_W           = 10,
  parameter int SPEED         = 4,
  parameter int SCREEN_W      = game_pkg::SCREEN_W,
  parameter int PROJ_W        = DEF_PROJ_W,
  parameter int PROJ_H        = DEF_PROJ_H,
  parameter int OPP_W         = DEF_OPP_W,
  parameter int OPP_H         = DEF_OPP_H,
  parameter int EXPLODE_TICKS = 8
`ifdef PROJECTILE_POOL_COOLDOWN_EN
  , parameter int COOLDOWN_TICKS = 32
`endif
)(
  input  logic                     clk,
  input  logic                     start,
  input  logic                     tick,
  input  logic                     fire,
  input  logic                     direction,
  input  logic [X_W-1:0]           start_x,
  input  logic [X_W-1:0]           start_y,
  input  logic [X_W-1:0]           opponent_x,
  input  logic [X_W-1:0]           opponent_y,
  output logic [2*NUM_SLOTS-1:0]   slot_state,
  output logic [X_W*NUM_SLOTS-1:0] slot_x,
  output logic [X_W*NUM_SLOTS-1:0] slot_y,
  output logic                     fire_ack,
  output logic                     fire_drop,
  output logic                     opponent_hit,
  output logic [7:0]               hit_count
);

  slot_state_t          st [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] idle;
  logic [NUM_SLOTS-1:0] hit;
  logic [NUM_SLOTS-1:0] free_sel;
  logic [NUM_SLOTS-1:0] spawn;
  logic                 cd_busy;
  logic                 accept;
  logic [3:0]           n_hits;
  logic [8:0]           hit_sum;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    projectile_slot #(
      .X_W           (X_W),
      .SPEED         (SPEED),
      .SCREEN_W      (SCREEN_W),
      .PROJ_W        (PROJ_W),
      .PROJ_H        (PROJ_H),
      .OPP_W         (OPP_W),
      .OPP_H         (OPP_H),
      .EXPLODE_TICKS (EXPLODE_TICKS)
    ) u_slot (
      .clk        (clk),
      .start      (start),
      .tick       (tick),
      .spawn      (spawn[i]),
      .direction  (direction),
      .spawn_x    (start_x),
      .spawn_y    (start_y),
      .opponent_x (opponent_x),
      .opponent_y (opponent_y),
      .state      (st[i]),
      .x          (slot_x[X_W*i +: X_W]),
      .y          (slot_y[X_W*i +: X_W]),
      .hit        (hit[i])
    );
    assign slot_state[2*i +: 2] = st[i];
    assign idle[i]              = (st[i] == IDLE);
  end

  // Lowest-index IDLE slot as a one-hot select
  always_comb begin
    free_sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (idle[i]) free_sel = '0;
      if (idle[i]) free_sel[i] = 1'b1;
    end
  end

  assign accept = fire && (|idle) && !cd_busy;
  assign spawn  = accept ? free_sel : '0;

`ifdef PROJECTILE_POOL_COOLDOWN_EN
  localparam int CD_W = $clog2(COOLDOWN_TICKS + 1);
  logic [CD_W-1:0] cooldown;
  assign cd_busy = (cooldown != '0);

  // Cooldown restarts on every accepted fire and drains on frame ticks
  always_ff @(posedge clk) begin
    if (start)                  cooldown <= '0;
    else if (accept)            cooldown <= CD_W'(COOLDOWN_TICKS);
    else if (tick && cd_busy)   cooldown <= cooldown - 1'b1;
  end
`else
  assign cd_busy = 1'b0;
`endif

  // Number of slots that hit on this tick, and the saturating running total
  always_comb begin
    n_hits = '0;
    for (int i = 0; i < NUM_SLOTS; i++) n_hits = n_hits + {3'b0, hit[i]};
    hit_sum = {1'b0, hit_count} + {5'b0, n_hits};
  end

  // Registered one-cycle pulses and hit total
  always_ff @(posedge clk) begin
    if (start) begin
      fire_ack     <= 1'b0;
      fire_drop    <= 1'b0;
      opponent_hit <= 1'b0;
      hit_count    <= '0;
    end else begin
      fire_ack     <= accept;
      fire_drop    <= fire && !accept;
      opponent_hit <= |hit;
      hit_count    <= hit_sum[8] ? 8'hFF : hit_sum[7:0];
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench for projectile_pool with default parameters.
// Inputs change 2 time units after a rising edge; outputs are checked at the same point.
// Ends with a single summary line.
module tb_projectile_pool;

  logic        clk = 1'b0;
  logic        start = 1'b1;
  logic        tick = 1'b0;
  logic        fire = 1'b0;
  logic        direction = 1'b0;
  logic [9:0]  start_x = '0;
  logic [9:0]  start_y = '0;
  logic [9:0]  opponent_x = 10'd300;
  logic [9:0]  opponent_y = 10'd400;
  logic [7:0]  slot_state;
  logic [39:0] slot_x;
  logic [39:0] slot_y;
  logic        fire_ack;
  logic        fire_drop;
  logic        opponent_hit;
  logic [7:0]  hit_count;

  int total = 0;
  int bad   = 0;

  projectile_pool dut (
    .clk          (clk),
    .start        (start),
    .tick         (tick),
    .fire         (fire),
    .direction    (direction),
    .start_x      (start_x),
    .start_y      (start_y),
    .opponent_x   (opponent_x),
    .opponent_y   (opponent_y),
    .slot_state   (slot_state),
    .slot_x       (slot_x),
    .slot_y       (slot_y),
    .fire_ack     (fire_ack),
    .fire_drop    (fire_drop),
    .opponent_hit (opponent_hit),
    .hit_count    (hit_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic spawn1(input logic [9:0] sx, input logic [9:0] sy, input logic d);
    start_x = sx; start_y = sy; direction = d; fire = 1'b1;
    cyc();
    fire = 1'b0;
  endtask

  function automatic logic [9:0] px(input int i);
    return slot_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] py(input int i);
    return slot_y[10*i +: 10];
  endfunction

  initial begin
    cyc(); cyc();
    start = 1'b0;
    chk("reset_state", slot_state, 8'h00);
    chk("reset_x", slot_x[31:0], 0);
    chk("reset_hits", hit_count, 0);
    chk("reset_ack", {fire_ack, fire_drop, opponent_hit}, 0);

`ifdef PROJECTILE_POOL_COOLDOWN_EN
    spawn1(10'd100, 10'd0, 1'b1);
    chk("cd_first_ack", fire_ack, 1);
    do_tick(10);
    spawn1(10'd100, 10'd0, 1'b1);
    chk("cd_early_drop", fire_drop, 1);
    chk("cd_early_state", slot_state, 8'h01);
    do_tick(22);
    spawn1(10'd100, 10'd0, 1'b1);
    chk("cd_late_ack", fire_ack, 1);
    chk("cd_late_state", slot_state, 8'h05);
    start = 1'b1; fire = 1'b1;
    cyc();
    start = 1'b0; fire = 1'b0;
    chk("cd_start_idle", slot_state, 8'h00);
    chk("cd_start_noack", fire_ack, 0);
`else
    // Single spawn and three moves to the right
    spawn1(10'd100, 10'd200, 1'b1);
    chk("spawn_state", slot_state, 8'h01);
    chk("spawn_x", px(0), 100);
    chk("spawn_y", py(0), 200);
    chk("spawn_ack", fire_ack, 1);
    chk("spawn_drop", fire_drop, 0);
    cyc();
    chk("ack_pulse_len", fire_ack, 0);
    do_tick(3);
    chk("move3_x", px(0), 112);

    // Held fire fills the pool, then drops
    do_reset();
    opponent_x = 10'd300; opponent_y = 10'd400;
    start_x = 10'd100; start_y = 10'd0; direction = 1'b1; fire = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("held_ack%0d", i), fire_ack, (i < 4) ? 1 : 0);
      chk($sformatf("held_drop%0d", i), fire_drop, (i < 4) ? 0 : 1);
    end
    fire = 1'b0;
    chk("held_state", slot_state, 8'h55);

    // Start mid-flight with a pending fire
    start = 1'b1; fire = 1'b1;
    cyc();
    start = 1'b0; fire = 1'b0;
    chk("start_idle", slot_state, 8'h00);
    chk("start_noack", fire_ack, 0);

    // Hit on the seventh tick at nx=128
    opponent_x = 10'd140; opponent_y = 10'd200;
    spawn1(10'd100, 10'd200, 1'b1);
    do_tick(6);
    chk("prehit_x", px(0), 124);
    chk("prehit_state", slot_state, 8'h01);
    chk("prehit_ohit", opponent_hit, 0);
    do_tick(1);
    chk("hit_state", slot_state, 8'h02);
    chk("hit_x", px(0), 128);
    chk("hit_pulse", opponent_hit, 1);
    chk("hit_count1", hit_count, 1);
    cyc();
    chk("hit_pulse_len", opponent_hit, 0);
    do_tick(7);
    chk("explode_hold", slot_state, 8'h02);
    do_tick(1);
    chk("explode_done", slot_state, 8'h00);
    chk("hit_count_keep", hit_count, 1);

    // Two slots hit on the same tick
    spawn1(10'd124, 10'd200, 1'b1);
    spawn1(10'd160, 10'd200, 1'b0);
    chk("pair_state", slot_state, 8'h05);
    do_tick(1);
    chk("pair_hit_state", slot_state, 8'h0A);
    chk("pair_x0", px(0), 128);
    chk("pair_x1", px(1), 156);
    chk("pair_pulse", opponent_hit, 1);
    chk("pair_count", hit_count, 3);
    cyc();
    chk("pair_pulse_len", opponent_hit, 0);

    // Screen edges, opponent out of the way
    do_reset();
    opponent_x = 10'd300; opponent_y = 10'd400;
    spawn1(10'd620, 10'd0, 1'b1);
    do_tick(1);
    chk("right_edge_stay", slot_state, 8'h01);
    chk("right_edge_x", px(0), 624);
    do_tick(1);
    chk("right_exit", slot_state, 8'h00);
    spawn1(10'd3, 10'd0, 1'b0);
    do_tick(1);
    chk("left_exit3", slot_state, 8'h00);
    spawn1(10'd4, 10'd0, 1'b0);
    do_tick(1);
    chk("left_edge_stay", slot_state, 8'h01);
    chk("left_edge_x", px(0), 0);
    do_tick(1);
    chk("left_exit0", slot_state, 8'h00);

    // Fire and tick in the same cycle
    spawn1(10'd500, 10'd0, 1'b1);
    start_x = 10'd200; direction = 1'b0; fire = 1'b1; tick = 1'b1;
    cyc();
    fire = 1'b0; tick = 1'b0;
    chk("ft_state", slot_state, 8'h05);
    chk("ft_moved", px(0), 504);
    chk("ft_unmoved", px(1), 200);
    do_tick(1);
    chk("ft_next_move", px(1), 196);

    // Hit counter saturation: 4 hits per round
    do_reset();
    opponent_x = 10'd140; opponent_y = 10'd200;
    for (int r = 0; r < 70; r++) begin
      start_x = 10'd124; start_y = 10'd200; direction = 1'b1; fire = 1'b1;
      repeat (4) cyc();
      fire = 1'b0;
      do_tick(9);
      if (r == 59) chk("count_240", hit_count, 240);
    end
    chk("count_sat", hit_count, 255);
    chk("sat_idle", slot_state, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
